// File: rtl/ca_signal_gen_if.sv
// ---------------------------------------------------------------------------
// ca_signal_gen_if
// Navigation-data word handshake between a data source (master) and the
// C/A signal generator (slave).
//   data_word   nav word, MSB transmitted first
//   data_valid  data_word is valid
//   data_ready  generator holding register is empty; word is taken on
//               a clock edge where data_valid & data_ready are both high
// ---------------------------------------------------------------------------
interface ca_signal_gen_if #(
  parameter int WORD_BITS = 30
) ();
  logic [WORD_BITS-1:0] data_word;
  logic                 data_valid;
  logic                 data_ready;

  modport master (output data_word, output data_valid, input data_ready);
  modport slave  (input data_word, input data_valid, output data_ready);
endinterface

// File: rtl/ca_signal_gen.sv
// ---------------------------------------------------------------------------
// ca_signal_gen
// Transmit-side GPS L1 C/A baseband source. A chip-rate NCO clocks the G1/G2
// Gold-code generators; every chip is XORed with the current 50 bps nav bit,
// one data bit lasting EPOCHS_PER_BIT code periods, words sent MSB first.
//
// Ports
//   clk, rst        system clock, synchronous active-high reset
//   prn_key_enable  pulse: load prn_key into G2, re-init generators, go IDLE
//                   (holding word and underrun flag are kept)
//   prn_key[9:0]    G2 initial state, selects the PRN
//   code_freq       NCO increment per clk
//   start           pulse: begin transmission (only honoured in IDLE)
//   preset_chips    (CODE_PRESET_EN only) starting code phase, clamped to 1022
//   data_if         slave side of the nav-word valid/ready handshake
//   chip_out        current C/A chip
//   sign_out        chip_out ^ current data bit
//   epoch           1-clk pulse with chip 0 of each code period
//   bit_edge        1-clk pulse with chip 0 of each new data bit
//   underrun        sticky: a word was needed but none was available
//   running         high while in RUN
//
// Optional feature: define CODE_PRESET_EN to add the preset_chips port and a
// PRESET state that slews the code phase one chip per clk before RUN.
// ---------------------------------------------------------------------------
module ca_signal_gen #(
  parameter int NCO_WIDTH      = 32,
  parameter int WORD_BITS      = 30,
  parameter int EPOCHS_PER_BIT = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 prn_key_enable,
  input  logic [9:0]           prn_key,
  input  logic [NCO_WIDTH-1:0] code_freq,
  input  logic                 start,
`ifdef CODE_PRESET_EN
  input  logic [9:0]           preset_chips,
`endif
  ca_signal_gen_if.slave       data_if,
  output logic                 chip_out,
  output logic                 sign_out,
  output logic                 epoch,
  output logic                 bit_edge,
  output logic                 underrun,
  output logic                 running
);

  localparam int EW = (EPOCHS_PER_BIT > 1) ? $clog2(EPOCHS_PER_BIT) : 1;
  localparam int BW = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
  localparam logic [9:0] LAST_CHIP = 10'd1022;

`ifdef CODE_PRESET_EN
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PRESET} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_RUN} state_t;
`endif

  // G1 feedback taps 3,10 and G2 taps 2,3,6,8,9,10 in a shift-right register
  function automatic logic [9:0] g1_step(input logic [9:0] g);
    return {g[7] ^ g[0], g[9:1]};
  endfunction

  function automatic logic [9:0] g2_step(input logic [9:0] g);
    return {g[8] ^ g[7] ^ g[4] ^ g[2] ^ g[1] ^ g[0], g[9:1]};
  endfunction

  state_t                 state_q, state_d;
  logic [NCO_WIDTH-1:0]   acc_q, acc_d;
  logic [9:0]             g1_q, g1_d;
  logic [9:0]             g2_q, g2_d;
  logic [9:0]             chip_cnt_q, chip_cnt_d;
  logic [EW-1:0]          epoch_cnt_q, epoch_cnt_d;
  logic                   edge_pend_q, edge_pend_d;
  logic [WORD_BITS-1:0]   sreg_q, sreg_d;
  logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
  logic                   word_live_q, word_live_d;
  logic [WORD_BITS-1:0]   hold_q, hold_d;
  logic                   hold_full_q, hold_full_d;
  logic                   underrun_q, underrun_d;
  logic                   chip_q, chip_d;
  logic                   sign_q, sign_d;
  logic                   epoch_q, epoch_d;
  logic                   bit_edge_q, bit_edge_d;
  logic [NCO_WIDTH:0]     nco_sum;
  logic                   chip_en;
  logic                   accept;
  logic                   load_req;
`ifdef CODE_PRESET_EN
  logic [9:0]             preset_cnt_q, preset_cnt_d;
  logic [9:0]             preset_clamped;

  assign preset_clamped = (preset_chips > LAST_CHIP) ? LAST_CHIP : preset_chips;
`endif

  // The NCO carry-out is the chip enable; only meaningful while running
  assign nco_sum = {1'b0, acc_q} + {1'b0, code_freq};
  assign chip_en = (state_q == ST_RUN) && nco_sum[NCO_WIDTH];
  assign accept  = data_if.data_valid && !hold_full_q;

  // Next-state logic. Epoch counting happens on the last chip of each period
  // and arms edge_pend, so the first data bit after start is a full
  // EPOCHS_PER_BIT periods long and bit_edge lands on the following chip 0.
  // A word boundary (or an underrun retry) raises load_req, which takes the
  // holding word, else a word being offered this very clk (bypass), else
  // falls back to transmitting zeros and flags underrun.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    g1_d        = g1_q;
    g2_d        = g2_q;
    chip_cnt_d  = chip_cnt_q;
    epoch_cnt_d = epoch_cnt_q;
    edge_pend_d = edge_pend_q;
    sreg_d      = sreg_q;
    bit_cnt_d   = bit_cnt_q;
    word_live_d = word_live_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    underrun_d  = underrun_q;
    chip_d      = chip_q;
    sign_d      = sign_q;
    epoch_d     = 1'b0;
    bit_edge_d  = 1'b0;
    load_req    = 1'b0;
`ifdef CODE_PRESET_EN
    preset_cnt_d = preset_cnt_q;
`endif

    if (accept) begin
      hold_d      = data_if.data_word;
      hold_full_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          load_req = 1'b1;
`ifdef CODE_PRESET_EN
          if (preset_clamped != 10'd0) begin
            state_d      = ST_PRESET;
            preset_cnt_d = preset_clamped;
          end else begin
            state_d = ST_RUN;
          end
`else
          state_d = ST_RUN;
`endif
        end
      end
      ST_RUN: begin
        acc_d = nco_sum[NCO_WIDTH-1:0];
        if (chip_en) begin
          chip_d     = g1_q[0] ^ g2_q[0];
          g1_d       = g1_step(g1_q);
          g2_d       = g2_step(g2_q);
          chip_cnt_d = (chip_cnt_q == LAST_CHIP) ? 10'd0 : chip_cnt_q + 10'd1;
          if (chip_cnt_q == 10'd0) begin
            epoch_d = 1'b1;
            if (edge_pend_q) begin
              bit_edge_d  = 1'b1;
              edge_pend_d = 1'b0;
              if (word_live_q && (bit_cnt_q != BW'(WORD_BITS - 1))) begin
                sreg_d    = sreg_q << 1;
                bit_cnt_d = bit_cnt_q + BW'(1);
              end else begin
                load_req = 1'b1;
              end
            end
          end
          if (chip_cnt_q == LAST_CHIP) begin
            if (epoch_cnt_q == EW'(EPOCHS_PER_BIT - 1)) begin
              epoch_cnt_d = '0;
              edge_pend_d = 1'b1;
            end else begin
              epoch_cnt_d = epoch_cnt_q + EW'(1);
            end
          end
        end
      end
`ifdef CODE_PRESET_EN
      ST_PRESET: begin
        g1_d         = g1_step(g1_q);
        g2_d         = g2_step(g2_q);
        chip_cnt_d   = (chip_cnt_q == LAST_CHIP) ? 10'd0 : chip_cnt_q + 10'd1;
        preset_cnt_d = preset_cnt_q - 10'd1;
        if (preset_cnt_q == 10'd1) begin
          state_d = ST_RUN;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    if (load_req) begin
      bit_cnt_d = '0;
      if (hold_full_q) begin
        sreg_d      = hold_q;
        word_live_d = 1'b1;
        hold_full_d = 1'b0;
      end else if (accept) begin
        sreg_d      = data_if.data_word;
        word_live_d = 1'b1;
        hold_full_d = 1'b0;
      end else begin
        sreg_d      = '0;
        word_live_d = 1'b0;
        underrun_d  = 1'b1;
      end
    end

    // New chip and (on a bit edge) new data bit go out together
    if (chip_en) begin
      sign_d = chip_d ^ sreg_d[WORD_BITS-1];
    end

    // PRN reload overrides everything except the holding word and underrun
    if (prn_key_enable) begin
      state_d     = ST_IDLE;
      acc_d       = '0;
      g1_d        = 10'h3FF;
      g2_d        = prn_key;
      chip_cnt_d  = '0;
      epoch_cnt_d = '0;
      edge_pend_d = 1'b0;
      sreg_d      = '0;
      bit_cnt_d   = '0;
      word_live_d = 1'b0;
      hold_d      = accept ? data_if.data_word : hold_q;
      hold_full_d = hold_full_q || accept;
      underrun_d  = underrun_q;
      chip_d      = 1'b0;
      sign_d      = 1'b0;
      epoch_d     = 1'b0;
      bit_edge_d  = 1'b0;
`ifdef CODE_PRESET_EN
      preset_cnt_d = '0;
`endif
    end
  end

  // State registers; rst wins over prn_key_enable because it is checked first
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      g1_q        <= 10'h3FF;
      g2_q        <= prn_key;
      chip_cnt_q  <= '0;
      epoch_cnt_q <= '0;
      edge_pend_q <= 1'b0;
      sreg_q      <= '0;
      bit_cnt_q   <= '0;
      word_live_q <= 1'b0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      underrun_q  <= 1'b0;
      chip_q      <= 1'b0;
      sign_q      <= 1'b0;
      epoch_q     <= 1'b0;
      bit_edge_q  <= 1'b0;
`ifdef CODE_PRESET_EN
      preset_cnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      g1_q        <= g1_d;
      g2_q        <= g2_d;
      chip_cnt_q  <= chip_cnt_d;
      epoch_cnt_q <= epoch_cnt_d;
      edge_pend_q <= edge_pend_d;
      sreg_q      <= sreg_d;
      bit_cnt_q   <= bit_cnt_d;
      word_live_q <= word_live_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      underrun_q  <= underrun_d;
      chip_q      <= chip_d;
      sign_q      <= sign_d;
      epoch_q     <= epoch_d;
      bit_edge_q  <= bit_edge_d;
`ifdef CODE_PRESET_EN
      preset_cnt_q <= preset_cnt_d;
`endif
    end
  end

  assign data_if.data_ready = !hold_full_q;
  assign chip_out           = chip_q;
  assign sign_out           = sign_q;
  assign epoch              = epoch_q;
  assign bit_edge           = bit_edge_q;
  assign underrun           = underrun_q;
  assign running            = (state_q == ST_RUN);

endmodule
